// File: rtl/wb_stage.sv
// Write-back stage: holds one instruction from MEM, aligns load data and
// drives the register-file write port, forwarding view, debug trace and retire count.
module wb_stage (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ms_to_ws_valid,
  output logic        ws_allowin,
  input  logic [31:0] ms_pc,
  input  logic        ms_gr_we,
  input  logic [4:0]  ms_dest,
  input  logic [2:0]  ms_load_op,
  input  logic [31:0] ms_result,
  input  logic [31:0] ms_mem_rdata,
  input  logic        ws_flush,
  input  logic        ws_stall,
  output logic [3:0]  rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        ws_fwd_valid,
  output logic [4:0]  ws_fwd_dest,
  output logic [31:0] ws_fwd_data,
  output logic [31:0] debug_wb_pc,
  output logic [3:0]  debug_wb_rf_wen,
  output logic [4:0]  debug_wb_rf_wnum,
  output logic [31:0] debug_wb_rf_wdata,
  output logic [31:0] ws_instret
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned RW   = 5;
  localparam int unsigned OPW  = 3;

  localparam logic [OPW-1:0] OP_ALU = 3'd0;
  localparam logic [OPW-1:0] OP_LB  = 3'd1;
  localparam logic [OPW-1:0] OP_LBU = 3'd2;
  localparam logic [OPW-1:0] OP_LH  = 3'd3;
  localparam logic [OPW-1:0] OP_LHU = 3'd4;
  localparam logic [OPW-1:0] OP_LW  = 3'd5;
  localparam logic [OPW-1:0] OP_LWL = 3'd6;
  localparam logic [OPW-1:0] OP_LWR = 3'd7;

  logic            ws_valid_q,   ws_valid_d;
  logic [XLEN-1:0] ws_pc_q,      ws_pc_d;
  logic            ws_gr_we_q,   ws_gr_we_d;
  logic [RW-1:0]   ws_dest_q,    ws_dest_d;
  logic [OPW-1:0]  ws_load_op_q, ws_load_op_d;
  logic [XLEN-1:0] ws_result_q,  ws_result_d;
  logic [XLEN-1:0] ws_rdata_q,   ws_rdata_d;
  logic [XLEN-1:0] ws_instret_q, ws_instret_d;

  logic            ws_ready_go;
  logic            allowin_c;
  logic            retire_c;
  logic            writer_c;
  logic [1:0]      addr_lo;
  logic [7:0]      byte_c;
  logic [15:0]     half_c;
  logic [3:0]      we_c;
  logic [XLEN-1:0] wdata_c;

  // Handshake and next-state for the single WS slot
  always_comb begin
    ws_valid_d   = ws_valid_q;
    ws_pc_d      = ws_pc_q;
    ws_gr_we_d   = ws_gr_we_q;
    ws_dest_d    = ws_dest_q;
    ws_load_op_d = ws_load_op_q;
    ws_result_d  = ws_result_q;
    ws_rdata_d   = ws_rdata_q;

    ws_ready_go  = !ws_stall;
    allowin_c    = !ws_valid_q || ws_ready_go;
    retire_c     = ws_valid_q && ws_ready_go;
    ws_instret_d = ws_instret_q + XLEN'(retire_c);

    if (allowin_c) begin
      ws_valid_d = ms_to_ws_valid && !ws_flush;
    end
    if (allowin_c && ms_to_ws_valid) begin
      ws_pc_d      = ms_pc;
      ws_gr_we_d   = ms_gr_we;
      ws_dest_d    = ms_dest;
      ws_load_op_d = ms_load_op;
      ws_result_d  = ms_result;
      ws_rdata_d   = ms_mem_rdata;
    end
  end

  // Load alignment; LWL/LWR merge into the old register via byte enables only
  always_comb begin
    addr_lo = ws_result_q[1:0];
    byte_c  = 8'(ws_rdata_q >> {addr_lo, 3'b000});
    half_c  = addr_lo[1] ? ws_rdata_q[31:16] : ws_rdata_q[15:0];
    we_c    = 4'b1111;
    wdata_c = ws_result_q;
    case (ws_load_op_q)
      OP_ALU: wdata_c = ws_result_q;
      OP_LB:  wdata_c = {{24{byte_c[7]}}, byte_c};
      OP_LBU: wdata_c = {24'd0, byte_c};
      OP_LH:  wdata_c = {{16{half_c[15]}}, half_c};
      OP_LHU: wdata_c = {16'd0, half_c};
      OP_LW:  wdata_c = ws_rdata_q;
      OP_LWL: begin
        wdata_c = ws_rdata_q << {2'(2'd3 - addr_lo), 3'b000};
        we_c    = 4'b1111 << (2'd3 - addr_lo);
      end
      OP_LWR: begin
        wdata_c = ws_rdata_q >> {addr_lo, 3'b000};
        we_c    = 4'b1111 >> addr_lo;
      end
      default: wdata_c = ws_result_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ws_valid_q   <= 1'b0;
      ws_pc_q      <= '0;
      ws_gr_we_q   <= 1'b0;
      ws_dest_q    <= '0;
      ws_load_op_q <= '0;
      ws_result_q  <= '0;
      ws_rdata_q   <= '0;
      ws_instret_q <= '0;
    end else begin
      ws_valid_q   <= ws_valid_d;
      ws_pc_q      <= ws_pc_d;
      ws_gr_we_q   <= ws_gr_we_d;
      ws_dest_q    <= ws_dest_d;
      ws_load_op_q <= ws_load_op_d;
      ws_result_q  <= ws_result_d;
      ws_rdata_q   <= ws_rdata_d;
      ws_instret_q <= ws_instret_d;
    end
  end

  assign writer_c          = ws_valid_q && ws_gr_we_q && (ws_dest_q != '0);
  assign ws_allowin        = allowin_c;
  assign rf_we             = (writer_c && retire_c) ? we_c : 4'b0000;
  assign rf_waddr          = ws_dest_q;
  assign rf_wdata          = wdata_c;
  assign ws_fwd_valid      = writer_c;
  assign ws_fwd_dest       = ws_dest_q;
  assign ws_fwd_data       = wdata_c;
  assign debug_wb_pc       = ws_pc_q;
  assign debug_wb_rf_wen   = rf_we;
  assign debug_wb_rf_wnum  = ws_dest_q;
  assign debug_wb_rf_wdata = wdata_c;
  assign ws_instret        = ws_instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed vector table, stall/flush/wrap
// sequences and a randomized run against an arithmetic reference model.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ms_to_ws_valid;
  logic        ws_allowin;
  logic [31:0] ms_pc;
  logic        ms_gr_we;
  logic [4:0]  ms_dest;
  logic [2:0]  ms_load_op;
  logic [31:0] ms_result;
  logic [31:0] ms_mem_rdata;
  logic        ws_flush;
  logic        ws_stall;
  logic [3:0]  rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        ws_fwd_valid;
  logic [4:0]  ws_fwd_dest;
  logic [31:0] ws_fwd_data;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;
  logic [31:0] ws_instret;

  int total = 0;
  int bad   = 0;

  // reference model state: the instruction sitting in WS and the retire count
  bit          m_valid;
  logic [31:0] m_pc, m_result, m_rdata, m_cnt;
  bit          m_gr_we;
  logic [4:0]  m_dest;
  logic [2:0]  m_op;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] result;
    logic [31:0] rdata;
    logic [4:0]  dest;
    logic [3:0]  exp_we;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vecs[12];

  wb_stage dut (
    .clk(clk), .resetn(resetn), .ms_to_ws_valid(ms_to_ws_valid), .ws_allowin(ws_allowin),
    .ms_pc(ms_pc), .ms_gr_we(ms_gr_we), .ms_dest(ms_dest), .ms_load_op(ms_load_op),
    .ms_result(ms_result), .ms_mem_rdata(ms_mem_rdata), .ws_flush(ws_flush), .ws_stall(ws_stall),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .ws_fwd_valid(ws_fwd_valid),
    .ws_fwd_dest(ws_fwd_dest), .ws_fwd_data(ws_fwd_data), .debug_wb_pc(debug_wb_pc),
    .debug_wb_rf_wen(debug_wb_rf_wen), .debug_wb_rf_wnum(debug_wb_rf_wnum),
    .debug_wb_rf_wdata(debug_wb_rf_wdata), .ws_instret(ws_instret)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected write data/enables from the load rules, using plain arithmetic
  task automatic ref_data(input logic [2:0] op, input logic [31:0] res, input logic [31:0] rd,
                          output logic [3:0] we, output logic [31:0] wd);
    int unsigned a, bv, hv;
    logic [3:0] full;
    a    = res % 4;
    bv   = (rd / (1 << (8 * a))) % 256;
    hv   = (a >= 2) ? rd / 65536 : rd % 65536;
    full = 4'hF;
    we   = 4'hF;
    case (op)
      3'd0: wd = res;
      3'd1: wd = (bv >= 128) ? bv + 32'hFFFFFF00 : bv;
      3'd2: wd = bv;
      3'd3: wd = (hv >= 32768) ? hv + 32'hFFFF0000 : hv;
      3'd4: wd = hv;
      3'd5: wd = rd;
      3'd6: begin wd = rd << (8 * (3 - a)); we = full << (3 - a); end
      default: begin wd = rd >> (8 * a); we = full >> a; end
    endcase
  endtask

  task automatic check_model();
    logic [3:0]  we;
    logic [31:0] wd;
    bit          wr;
    ref_data(m_op, m_result, m_rdata, we, wd);
    wr = m_valid && m_gr_we && (m_dest != 0);
    chk("allowin", 32'(ws_allowin), 32'(!m_valid || !ws_stall));
    chk("rf_we", 32'(rf_we), (wr && !ws_stall) ? 32'(we) : 32'd0);
    chk("rf_waddr", 32'(rf_waddr), 32'(m_dest));
    chk("rf_wdata", rf_wdata, wd);
    chk("fwd_valid", 32'(ws_fwd_valid), 32'(wr));
    chk("fwd_dest", 32'(ws_fwd_dest), 32'(m_dest));
    chk("fwd_data", ws_fwd_data, wd);
    chk("dbg_pc", debug_wb_pc, m_pc);
    chk("dbg_wen", 32'(debug_wb_rf_wen), 32'(rf_we));
    chk("dbg_wnum", 32'(debug_wb_rf_wnum), 32'(m_dest));
    chk("dbg_wdata", debug_wb_rf_wdata, wd);
    chk("instret", ws_instret, m_cnt);
  endtask

  task automatic model_edge();
    bit allow;
    if (!resetn) begin
      m_valid = 0; m_pc = 0; m_gr_we = 0; m_dest = 0; m_op = 0;
      m_result = 0; m_rdata = 0; m_cnt = 0;
    end else begin
      allow = !m_valid || !ws_stall;
      if (m_valid && !ws_stall) m_cnt = m_cnt + 1;
      if (allow && ms_to_ws_valid) begin
        m_pc = ms_pc; m_gr_we = ms_gr_we; m_dest = ms_dest; m_op = ms_load_op;
        m_result = ms_result; m_rdata = ms_mem_rdata;
      end
      if (allow) m_valid = ms_to_ws_valid && !ws_flush;
    end
  endtask

  // Called at a negedge after inputs are driven: check, clock once, return at next negedge
  task automatic step(input bit do_check = 1);
    #1;
    if (do_check) check_model();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic offer(input logic [2:0] op, input logic [31:0] res, input logic [31:0] rd,
                       input logic [4:0] dest, input bit gr_we);
    ms_to_ws_valid = 1; ms_load_op = op; ms_result = res; ms_mem_rdata = rd;
    ms_dest = dest; ms_gr_we = gr_we; ms_pc = ms_pc + 4;
  endtask

  initial begin
    logic [31:0] cnt0;
    vecs[0]  = '{3'd0, 32'h12345678, 32'h0,        5'd5, 4'b1111, 32'h12345678};
    vecs[1]  = '{3'd0, 32'h12345678, 32'h0,        5'd0, 4'b0000, 32'h12345678};
    vecs[2]  = '{3'd1, 32'h00001001, 32'h8899AABB, 5'd2, 4'b1111, 32'hFFFFFFAA};
    vecs[3]  = '{3'd2, 32'h00001003, 32'h8899AABB, 5'd3, 4'b1111, 32'h00000088};
    vecs[4]  = '{3'd3, 32'h00001002, 32'h8899AABB, 5'd4, 4'b1111, 32'hFFFF8899};
    vecs[5]  = '{3'd4, 32'h00001000, 32'h8899AABB, 5'd6, 4'b1111, 32'h0000AABB};
    vecs[6]  = '{3'd6, 32'h00001001, 32'h8899AABB, 5'd7, 4'b1100, 32'hAABB0000};
    vecs[7]  = '{3'd7, 32'h00001002, 32'h8899AABB, 5'd8, 4'b0011, 32'h00008899};
    vecs[8]  = '{3'd5, 32'h00001000, 32'h8899AABB, 5'd9, 4'b1111, 32'h8899AABB};
    vecs[9]  = '{3'd6, 32'h00001003, 32'h8899AABB, 5'd10, 4'b1111, 32'h8899AABB};
    vecs[10] = '{3'd7, 32'h00001000, 32'h8899AABB, 5'd11, 4'b1111, 32'h8899AABB};
    vecs[11] = '{3'd2, 32'h00001000, 32'h8899AABB, 5'd31, 4'b1111, 32'h000000BB};

    resetn = 0; ms_to_ws_valid = 1; ms_pc = 32'hBFC00000; ms_gr_we = 1; ms_dest = 5'd3;
    ms_load_op = 0; ms_result = 32'hCAFE0000; ms_mem_rdata = 0; ws_flush = 0; ws_stall = 0;
    @(negedge clk);
    step(0);
    #1;
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    chk("rst_instret", ws_instret, 32'd0);
    chk("rst_allowin", 32'(ws_allowin), 32'd1);
    chk("rst_fwd_valid", 32'(ws_fwd_valid), 32'd0);
    step();
    // first release edge accepts the offered instruction
    resetn = 1;
    step();
    ms_to_ws_valid = 0;
    #1;
    chk("rel_rf_we", 32'(rf_we), 32'hF);
    chk("rel_wdata", rf_wdata, 32'hCAFE0000);
    step();

    for (int i = 0; i < 12; i++) begin
      offer(vecs[i].op, vecs[i].result, vecs[i].rdata, vecs[i].dest, 1);
      step();
      ms_to_ws_valid = 0;
      cnt0 = m_cnt;
      #1;
      chk($sformatf("vec%0d_we", i), 32'(rf_we), 32'(vecs[i].exp_we));
      chk($sformatf("vec%0d_wdata", i), rf_wdata, vecs[i].exp_wdata);
      chk($sformatf("vec%0d_waddr", i), 32'(rf_waddr), 32'(vecs[i].dest));
      step();
      chk($sformatf("vec%0d_instret", i), ws_instret, cnt0 + 1);
    end

    // stall: held writer, no write for 3 cycles, then exactly one write
    offer(3'd0, 32'h00000055, 32'h0, 5'd7, 1);
    step();
    cnt0 = m_cnt;
    offer(3'd0, 32'hDEAD0000, 32'h0, 5'd9, 1);
    ws_stall = 1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall_we", 32'(rf_we), 32'd0);
      chk("stall_allowin", 32'(ws_allowin), 32'd0);
      chk("stall_fwd", 32'(ws_fwd_valid), 32'd1);
      chk("stall_data", rf_wdata, 32'h00000055);
      step();
    end
    ws_stall = 0; ms_to_ws_valid = 0;
    #1;
    chk("unstall_we", 32'(rf_we), 32'hF);
    step();
    chk("unstall_instret", ws_instret, cnt0 + 1);
    chk("unstall_idle_we", 32'(rf_we), 32'd0);

    // flush into an empty WS: nothing lands
    offer(3'd0, 32'h11111111, 32'h0, 5'd12, 1);
    ws_flush = 1;
    step();
    ws_flush = 0; ms_to_ws_valid = 0;
    #1;
    chk("flush_we", 32'(rf_we), 32'd0);
    chk("flush_fwd", 32'(ws_fwd_valid), 32'd0);
    step();
    // flush with an occupant: occupant still retires
    offer(3'd0, 32'h22222222, 32'h0, 5'd13, 1);
    step();
    offer(3'd0, 32'h33333333, 32'h0, 5'd14, 1);
    ws_flush = 1;
    #1;
    chk("flush_occ_we", 32'(rf_we), 32'hF);
    step();
    ws_flush = 0; ms_to_ws_valid = 0;
    #1;
    chk("flush_occ_after", 32'(ws_fwd_valid), 32'd0);
    step();

    // counter wrap
    force dut.ws_instret_q = 32'hFFFFFFFF;
    #1;
    release dut.ws_instret_q;
    m_cnt = 32'hFFFFFFFF;
    offer(3'd0, 32'h44444444, 32'h0, 5'd15, 1);
    step();
    ms_to_ws_valid = 0;
    step();
    chk("wrap_instret", ws_instret, 32'd0);

    // randomized run against the model
    for (int n = 0; n < 600; n++) begin
      resetn         = ($urandom_range(0, 99) >= 2);
      ws_stall       = ($urandom_range(0, 3) == 0);
      ws_flush       = ($urandom_range(0, 6) == 0);
      ms_to_ws_valid = ($urandom_range(0, 9) < 7);
      ms_pc          = $urandom;
      ms_gr_we       = ($urandom_range(0, 7) != 0);
      ms_dest        = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      ms_load_op     = 3'($urandom);
      ms_result      = $urandom;
      ms_mem_rdata   = $urandom;
      step();
    end
    resetn = 1; ws_stall = 0; ws_flush = 0; ms_to_ws_valid = 0;
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
